hilo_mult_ctrl: RTL and testbench

- Sequencer that owns the HI/LO register pair and executes MULT, MULTU, MADD, MSUB, MTHI and MTLO as a multi-cycle operation.
- Replaces single-cycle combinational 64-bit multiply/accumulate in the execute stage with an iterative shift-add engine.
- Sits beside the ALU in EX; decode/hazard logic consumes Stall for MFHI/MFLO.

---
 rtl/hilo_pkg.sv | 31 +++
 rtl/hilo_mult_ctrl_if.sv | 25 ++
 rtl/mult_iter_core.sv | 41 ++++
 rtl/hilo_mult_ctrl.sv | 117 +++++++++++
 tb/tb_hilo_mult_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply sequencer: op and state encodings,
// iteration-width legality and iteration count.
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MSUB  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2,
    ACC  = 2'd3
  } state_e;

  function automatic bit iter_bits_legal(input int ib);
    return (ib == 1) || (ib == 2) || (ib == 4);
  endfunction

  function automatic int iter_count(input int ib);
    return 32 / ib;
  endfunction

endpackage

// File: rtl/hilo_mult_ctrl_if.sv
// Request/response bundle between the EX-stage issue logic and the HI/LO
// sequencer; the issuing side is the master.
interface hilo_mult_ctrl_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        MfReq;
  logic        Ready;
  logic        Busy;
  logic        Done;
  logic        Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, Op, A, B, MfReq,
    input  Ready, Busy, Done, Stall, HI, LO
  );

  modport slave (
    input  Start, Op, A, B, MfReq,
    output Ready, Busy, Done, Stall, HI, LO
  );
endinterface

// File: rtl/mult_iter_core.sv
// Unsigned 32x32 shift-add multiplier retiring ITER_BITS multiplier bits per
// step, LSB first, plus an in-place two's-complement negate of the product.
module mult_iter_core #(
  parameter int ITER_BITS = 1
) (
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  input  logic        neg,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic [63:0] prod
);

  logic [63:0] mcand_sh;
  logic [31:0] mplier_sh;
  logic [63:0] addend;

  always_comb begin
    addend = '0;
    for (int i = 0; i < ITER_BITS; i++) begin
      if (mplier_sh[i]) addend = addend + (mcand_sh << i);
    end
  end

  // Pure datapath: load takes priority so a new operation always starts clean.
  always_ff @(posedge clk) begin
    if (load) begin
      mcand_sh  <= {32'd0, mcand};
      mplier_sh <= mplier;
      prod      <= '0;
    end else if (step) begin
      prod      <= prod + addend;
      mcand_sh  <= mcand_sh << ITER_BITS;
      mplier_sh <= mplier_sh >> ITER_BITS;
    end else if (neg) begin
      prod      <= -prod;
    end
  end

endmodule

// File: rtl/hilo_mult_ctrl.sv
// HI/LO register owner: sequences MULT/MULTU/MADD/MSUB through the iterative
// core and performs MTHI/MTLO directly.
module hilo_mult_ctrl
  import hilo_pkg::*;
#(
  parameter int ITER_BITS = 1
) (
  input  logic           Clk,
  input  logic           Reset,
  hilo_mult_ctrl_if.slave bus
);

  localparam int N  = iter_count(ITER_BITS);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!iter_bits_legal(ITER_BITS)) begin : g_bad_iter
    $error("hilo_mult_ctrl: ITER_BITS must be 1, 2 or 4");
  end

  state_e        state;
  logic [CW-1:0] cnt;
  logic          busy_q;
  logic          done_q;
  logic          sign_q;
  op_e           op_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;

  op_e           op_in;
  logic          start_mul;
  logic [31:0]   mcand_in;
  logic [31:0]   mplier_in;
  logic [63:0]   prod;

  // Magnitude of a signed word; 0x80000000 maps to itself as unsigned.
  function automatic logic [31:0] mag(input logic signed [31:0] v);
    return v[31] ? 32'(-v) : 32'(v);
  endfunction

  assign op_in     = op_e'(bus.Op);
  assign start_mul = (state == IDLE) && bus.Start && !bus.Op[2];
  assign mcand_in  = (op_in == OP_MULTU) ? bus.A : mag(bus.A);
  assign mplier_in = (op_in == OP_MULTU) ? bus.B : mag(bus.B);

  mult_iter_core #(
    .ITER_BITS(ITER_BITS)
  ) u_core (
    .clk    (Clk),
    .load   (start_mul),
    .step   (state == MUL),
    .neg    ((state == FIX) && sign_q),
    .mcand  (mcand_in),
    .mplier (mplier_in),
    .prod   (prod)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sign_q <= 1'b0;
      op_q   <= OP_MULT;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            case (op_in)
              OP_MTHI: hi_q <= bus.A;
              OP_MTLO: lo_q <= bus.A;
              OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                sign_q <= (op_in == OP_MULTU) ? 1'b0 : (bus.A[31] ^ bus.B[31]);
                op_q   <= op_in;
                cnt    <= '0;
                busy_q <= 1'b1;
                state  <= MUL;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          cnt   <= '0;
          state <= ACC;
        end
        ACC: begin
          case (op_q)
            OP_MADD: {hi_q, lo_q} <= {hi_q, lo_q} + prod;
            OP_MSUB: {hi_q, lo_q} <= {hi_q, lo_q} - prod;
            default: {hi_q, lo_q} <= prod;
          endcase
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy  = busy_q;
  assign bus.Ready = ~busy_q;
  assign bus.Done  = done_q;
  assign bus.Stall = bus.MfReq & busy_q;
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Scoreboard bench for hilo_mult_ctrl: one instance per legal ITER_BITS, each
// with an expected-result queue drained by a monitor on Done.
module tb_hilo_mult_ctrl;
  import hilo_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_mult_ctrl_if bus1 ();
  hilo_mult_ctrl_if bus2 ();
  hilo_mult_ctrl_if bus4 ();

  hilo_mult_ctrl #(.ITER_BITS(1)) dut1 (.Clk(clk), .Reset(rst), .bus(bus1));
  hilo_mult_ctrl #(.ITER_BITS(2)) dut2 (.Clk(clk), .Reset(rst), .bus(bus2));
  hilo_mult_ctrl #(.ITER_BITS(4)) dut4 (.Clk(clk), .Reset(rst), .bus(bus4));

  int total = 0;
  int bad   = 0;
  logic [63:0] q1[$];
  logic [63:0] q2[$];
  logic [63:0] q4[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitors: pop the expected {HI,LO} whenever a Done pulse is presented.
  always @(negedge clk) begin
    if (bus1.Done) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL sb1 unexpected Done act=%h exp=none", {bus1.HI, bus1.LO});
      end else chk("sb1_hilo", {bus1.HI, bus1.LO}, q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (bus2.Done) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL sb2 unexpected Done act=%h exp=none", {bus2.HI, bus2.LO});
      end else chk("sb2_hilo", {bus2.HI, bus2.LO}, q2.pop_front());
    end
  end

  always @(negedge clk) begin
    if (bus4.Done) begin
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL sb4 unexpected Done act=%h exp=none", {bus4.HI, bus4.LO});
      end else chk("sb4_hilo", {bus4.HI, bus4.LO}, q4.pop_front());
    end
  end

  function automatic logic get_done(input int d);
    case (d)
      1:       return bus1.Done;
      2:       return bus2.Done;
      default: return bus4.Done;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      1:       return bus1.Busy;
      2:       return bus2.Busy;
      default: return bus4.Busy;
    endcase
  endfunction

  function automatic logic [63:0] get_hilo(input int d);
    case (d)
      1:       return {bus1.HI, bus1.LO};
      2:       return {bus2.HI, bus2.LO};
      default: return {bus4.HI, bus4.LO};
    endcase
  endfunction

  task automatic start(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (d)
      1:       begin bus1.Start = 1'b1; bus1.Op = op; bus1.A = a; bus1.B = b; end
      2:       begin bus2.Start = 1'b1; bus2.Op = op; bus2.A = a; bus2.B = b; end
      default: begin bus4.Start = 1'b1; bus4.Op = op; bus4.A = a; bus4.B = b; end
    endcase
  endtask

  task automatic stop(input int d);
    case (d)
      1:       begin bus1.Start = 1'b0; bus1.A = 32'hDEAD_BEEF; bus1.B = 32'hDEAD_BEEF; end
      2:       begin bus2.Start = 1'b0; bus2.A = 32'hDEAD_BEEF; bus2.B = 32'hDEAD_BEEF; end
      default: begin bus4.Start = 1'b0; bus4.A = 32'hDEAD_BEEF; bus4.B = 32'hDEAD_BEEF; end
    endcase
  endtask

  // Issue one multiply-class op and follow it to its Done cycle.
  // lat = edges from accept until Done is visible; bc = Busy cycles seen.
  task automatic run_op(input int d, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat, output int bc);
    logic [63:0] prev;
    int unstable;
    prev = get_hilo(d);
    start(d, op, a, b);
    @(posedge clk); #1;
    stop(d);
    lat = 1; bc = 0; unstable = 0;
    while (!get_done(d) && lat < 100) begin
      if (get_busy(d)) bc++;
      if (get_hilo(d) !== prev) unstable++;
      @(posedge clk); #1;
      lat++;
    end
    if (!get_done(d)) begin
      total++; bad++;
      $display("FAIL timeout_done d=%0d act=no_done exp=done", d);
    end
    chk("hilo_stable_busy", 64'(unstable), 64'd0);
    chk("busy_in_done", {63'd0, get_busy(d)}, 64'd0);
  endtask

  task automatic mt(input int d, input logic [2:0] op, input logic [31:0] a);
    start(d, op, a, 32'd0);
    @(posedge clk); #1;
    stop(d);
  endtask

  int lat, bc, n, cnt_bad;

  initial begin
    rst = 1'b1;
    bus1.Start = 0; bus1.Op = 0; bus1.A = 0; bus1.B = 0; bus1.MfReq = 0;
    bus2.Start = 0; bus2.Op = 0; bus2.A = 0; bus2.B = 0; bus2.MfReq = 0;
    bus4.Start = 0; bus4.Op = 0; bus4.A = 0; bus4.B = 0; bus4.MfReq = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_hilo", {bus1.HI, bus1.LO}, 64'd0);
    chk("rst_busy", {63'd0, bus1.Busy}, 64'd0);
    chk("rst_done", {63'd0, bus1.Done}, 64'd0);
    chk("rst_ready", {63'd0, bus1.Ready}, 64'd1);

    // Signed MULT -3 x 7
    q1.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    run_op(1, OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, bc);
    chk("mult_latency", 64'(lat - 1), 64'd34);
    chk("mult_busy_cycles", 64'(bc), 64'd34);
    @(posedge clk); #1;
    chk("done_one_cycle", {63'd0, bus1.Done}, 64'd0);

    // MULTU all-ones, then MULT of the most negative values back to back
    q1.push_back(64'hFFFF_FFFE_0000_0001);
    run_op(1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    q1.push_back(64'h4000_0000_0000_0000);
    run_op(1, OP_MULT, 32'h8000_0000, 32'h8000_0000, lat, bc);
    @(posedge clk); #1;

    // Accumulate sequence
    mt(1, OP_MTHI, 32'd5);
    chk("mthi_hi", {32'd0, bus1.HI}, 64'd5);
    chk("mthi_no_busy", {63'd0, bus1.Busy}, 64'd0);
    chk("mthi_no_done", {63'd0, bus1.Done}, 64'd0);
    mt(1, OP_MTLO, 32'd10);
    chk("mtlo_hilo", {bus1.HI, bus1.LO}, {32'd5, 32'd10});
    q1.push_back({32'd5, 32'h10});
    run_op(1, OP_MADD, 32'd2, 32'd3, lat, bc);
    q1.push_back({32'd5, 32'h0});
    run_op(1, OP_MSUB, 32'd4, 32'd4, lat, bc);
    q1.push_back({32'd4, 32'hFFFF_FFFF});
    run_op(1, OP_MSUB, 32'd1, 32'd1, lat, bc);
    @(posedge clk); #1;

    // Start ignored while Busy; Stall follows Busy while MfReq is held
    bus1.MfReq = 1'b1;
    q1.push_back({32'd0, 32'd15});
    start(1, OP_MULT, 32'd3, 32'd5);
    @(posedge clk); #1;
    stop(1);
    n = 0; cnt_bad = 0;
    while (!bus1.Done && n < 100) begin
      if (n == 3) start(1, OP_MTHI, 32'h1234, 32'd0);
      if (n == 4) stop(1);
      if (bus1.Stall !== 1'b1) cnt_bad++;
      @(posedge clk); #1;
      n++;
    end
    chk("stall_during_busy", 64'(cnt_bad), 64'd0);
    chk("stall_busy_cycles", 64'(n), 64'd34);
    chk("stall_in_done", {63'd0, bus1.Stall}, 64'd0);
    chk("ignored_mthi_hi", {32'd0, bus1.HI}, 64'd0);
    bus1.MfReq = 1'b0;
    @(posedge clk); #1;

    // Reset in MUL cycle 10 aborts without a later write
    mt(1, OP_MTHI, 32'd5);
    mt(1, OP_MTLO, 32'd10);
    start(1, OP_MULT, 32'd9, 32'd9);
    @(posedge clk); #1;
    stop(1);
    repeat (9) begin @(posedge clk); #1; end
    chk("pre_reset_busy", {63'd0, bus1.Busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_hilo", {bus1.HI, bus1.LO}, 64'd0);
    chk("abort_busy", {63'd0, bus1.Busy}, 64'd0);
    chk("abort_done", {63'd0, bus1.Done}, 64'd0);
    cnt_bad = 0;
    repeat (40) begin
      if (bus1.Done || bus1.Busy || ({bus1.HI, bus1.LO} != 64'd0)) cnt_bad++;
      @(posedge clk); #1;
    end
    chk("abort_no_late_write", 64'(cnt_bad), 64'd0);

    // Back-to-back: second Start issued in the Done cycle, each width
    q1.push_back({32'd0, 32'd6});
    run_op(1, OP_MULT, 32'd2, 32'd3, lat, bc);
    q1.push_back({32'd0, 32'd42});
    run_op(1, OP_MULT, 32'd6, 32'd7, lat, bc);
    chk("b2b_latency_1", 64'(lat - 1), 64'd34);
    chk("b2b_busy_1", 64'(bc), 64'd34);

    q2.push_back({32'd0, 32'd6});
    run_op(2, OP_MULT, 32'd2, 32'd3, lat, bc);
    q2.push_back({32'd0, 32'd42});
    run_op(2, OP_MULT, 32'd6, 32'd7, lat, bc);
    chk("b2b_latency_2", 64'(lat - 1), 64'd18);
    chk("b2b_busy_2", 64'(bc), 64'd18);

    q4.push_back({32'd0, 32'd6});
    run_op(4, OP_MULT, 32'd2, 32'd3, lat, bc);
    q4.push_back({32'd0, 32'd42});
    run_op(4, OP_MULT, 32'd6, 32'd7, lat, bc);
    chk("b2b_latency_4", 64'(lat - 1), 64'd10);
    chk("b2b_busy_4", 64'(bc), 64'd10);
    q4.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    run_op(4, OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, bc);

    repeat (3) @(posedge clk);
    #1;
    chk("sb1_drained", 64'(q1.size()), 64'd0);
    chk("sb2_drained", 64'(q2.size()), 64'd0);
    chk("sb4_drained", 64'(q4.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
